// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared widths, run-state encoding and wrap compare for the PWM block
package pwm_pkg;

   localparam int PERIOD_W   = 16;
   localparam int PRESCALE_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      PEND = 2'd2
   } run_state_t;

   // An up counter wraps by dropping, a down counter by jumping up.
   function automatic logic crossed(
      input logic                up,
      input logic [PERIOD_W-1:0] cur,
      input logic [PERIOD_W-1:0] prev
   );
      return up ? (cur < prev) : (cur > prev);
   endfunction

endpackage

// File: rtl/wrap_detect.sv
// rtl/wrap_detect.sv - period wrap detector on the live counter value
module wrap_detect
   import pwm_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic [PERIOD_W-1:0] count_val,
   input  logic                act_dir,
   input  logic                count_reset,
   output logic                wrap
);

   logic [PERIOD_W-1:0] r_prev_cnt;
   logic                r_mask;

   // The drop caused by a counter reset is not a wrap, so mask the cycle it lands in.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_prev_cnt <= '0;
         r_mask     <= 1'b1;
      end else begin
         r_prev_cnt <= count_val;
         r_mask     <= count_reset;
      end
   end

   assign wrap = !r_mask && crossed(act_dir, count_val, r_prev_cnt);

endmodule

// File: rtl/counter_ctrl.sv
// rtl/counter_ctrl.sv - run control and config update sequencer for the PWM period counter
module counter_ctrl
   import pwm_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  stop,
   input  logic                  cfg_valid,
   output logic                  cfg_ready,
   input  logic [PERIOD_W-1:0]   cfg_period,
   input  logic [PRESCALE_W-1:0] cfg_prescale,
   input  logic                  cfg_upnotdown,
   input  logic                  cfg_immediate,
   input  logic [PERIOD_W-1:0]   count_val,
   output logic [PERIOD_W-1:0]   period,
   output logic [PRESCALE_W-1:0] prescale,
   output logic                  upnotdown,
   output logic                  en,
   output logic                  count_reset,
   output logic                  upd_done,
   output logic                  period_done
);

   run_state_t            r_state;
   run_state_t            w_state_nxt;
   logic [PERIOD_W-1:0]   r_period;
   logic [PRESCALE_W-1:0] r_prescale;
   logic                  r_upnotdown;
   logic                  r_act_dir;
   logic                  r_en;
   logic                  r_cfg_ready;
   logic                  r_count_reset;
   logic                  r_upd_done;
   logic                  r_period_done;

   logic                  w_wrap;
   logic                  w_accept;
   logic                  w_promote;
   logic                  w_act_dir_nxt;
   logic                  w_count_reset_nxt;
   logic                  w_upd_done_nxt;
   logic                  w_period_done_nxt;

   wrap_detect u_wrap_detect (
      .clk         (clk),
      .rst_n       (rst_n),
      .count_val   (count_val),
      .act_dir     (r_act_dir),
      .count_reset (r_count_reset),
      .wrap        (w_wrap)
   );

   assign w_accept  = cfg_valid && (r_state != PEND);
   // A zero period never wraps, so a deferred update would wait forever.
   assign w_promote = cfg_immediate || (r_period == '0);

   always_comb begin
      w_state_nxt       = r_state;
      w_count_reset_nxt = 1'b0;
      w_upd_done_nxt    = 1'b0;
      w_period_done_nxt = 1'b0;
      w_act_dir_nxt     = r_act_dir;

      if (r_count_reset || (r_upd_done && r_state == IDLE)) begin
         w_act_dir_nxt = r_upnotdown;
      end

      case (r_state)
         IDLE: begin
            w_upd_done_nxt = w_accept;
            if (start && !stop) begin
               w_state_nxt       = RUN;
               w_count_reset_nxt = 1'b1;
            end
         end
         RUN: begin
            w_period_done_nxt = w_wrap;
            if (stop) begin
               w_state_nxt    = IDLE;
               w_upd_done_nxt = w_accept;
            end else if (w_accept) begin
               if (w_promote) begin
                  w_count_reset_nxt = 1'b1;
                  w_upd_done_nxt    = 1'b1;
               end else begin
                  w_state_nxt = PEND;
               end
            end
         end
         PEND: begin
            w_period_done_nxt = w_wrap;
            if (stop) begin
               w_state_nxt    = IDLE;
               w_upd_done_nxt = 1'b1;
            end else if (w_wrap) begin
               w_state_nxt    = RUN;
               w_upd_done_nxt = 1'b1;
               w_act_dir_nxt  = r_upnotdown;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state       <= IDLE;
         r_period      <= '0;
         r_prescale    <= '0;
         r_upnotdown   <= 1'b0;
         r_act_dir     <= 1'b0;
         r_en          <= 1'b0;
         r_cfg_ready   <= 1'b1;
         r_count_reset <= 1'b0;
         r_upd_done    <= 1'b0;
         r_period_done <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_act_dir     <= w_act_dir_nxt;
         r_en          <= (w_state_nxt != IDLE);
         r_cfg_ready   <= (w_state_nxt != PEND);
         r_count_reset <= w_count_reset_nxt;
         r_upd_done    <= w_upd_done_nxt;
         r_period_done <= w_period_done_nxt;
         if (w_accept) begin
            r_period    <= cfg_period;
            r_prescale  <= cfg_prescale;
            r_upnotdown <= cfg_upnotdown;
         end
      end
   end

   assign cfg_ready   = r_cfg_ready;
   assign period      = r_period;
   assign prescale    = r_prescale;
   assign upnotdown   = r_upnotdown;
   assign en          = r_en;
   assign count_reset = r_count_reset;
   assign upd_done    = r_upd_done;
   assign period_done = r_period_done;

endmodule

// File: tb/tb_counter_ctrl.sv
// tb/tb_counter_ctrl.sv - directed and randomized check of counter_ctrl against a cycle reference model
module tb_counter_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, start, stop, cfg_valid, cfg_upnotdown, cfg_immediate;
   logic [15:0] cfg_period, count_val, period;
   logic [7:0]  cfg_prescale, prescale;
   logic        cfg_ready, upnotdown, en, count_reset, upd_done, period_done;

   int n_vec = 0;
   int n_bad = 0;

   // PWM counter environment driving count_val from the controller's outputs
   int   e_cnt = 0, e_pre = 0, e_per = 0, e_psc = 0;
   logic e_up = 1'b0;

   // reference model: mode 0 idle, 1 running, 2 update pending
   int          m_mode = 0;
   logic [15:0] m_per  = '0;
   logic [7:0]  m_psc  = '0;
   logic        m_up = 1'b0, m_dir = 1'b0, m_mask = 1'b1;
   logic [15:0] m_prev = '0;
   logic        m_cr = 1'b0, m_ud = 1'b0, m_pd = 1'b0;

   int cv_now = 0, cv_p1 = 0;

   counter_ctrl dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .stop          (stop),
      .cfg_valid     (cfg_valid),
      .cfg_ready     (cfg_ready),
      .cfg_period    (cfg_period),
      .cfg_prescale  (cfg_prescale),
      .cfg_upnotdown (cfg_upnotdown),
      .cfg_immediate (cfg_immediate),
      .count_val     (count_val),
      .period        (period),
      .prescale      (prescale),
      .upnotdown     (upnotdown),
      .en            (en),
      .count_reset   (count_reset),
      .upd_done      (upd_done),
      .period_done   (period_done)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cycle();
      logic [29:0] got, want;
      logic        wrap, acc;
      int          n_mode;
      logic [15:0] n_per, n_prev;
      logic [7:0]  n_psc;
      logic        n_up, n_dir, n_mask, n_cr, n_ud, n_pd;
      int          ne_cnt, ne_pre, ne_per, ne_psc;
      logic        ne_up;

      @(negedge clk);
      cv_p1  = cv_now;
      cv_now = int'(count_val);
      got  = {cfg_ready, period, prescale, upnotdown, en, count_reset, upd_done, period_done};
      want = {m_mode != 2, m_per, m_psc, m_up, m_mode != 0, m_cr, m_ud, m_pd};
      chk("outputs", 32'(got), 32'(want));

      wrap   = !m_mask && (m_dir ? (count_val < m_prev) : (count_val > m_prev));
      acc    = cfg_valid && (m_mode != 2);
      n_mode = m_mode;
      n_cr   = 1'b0;
      n_ud   = 1'b0;
      n_pd   = 1'b0;
      n_dir  = m_dir;
      n_per  = acc ? cfg_period    : m_per;
      n_psc  = acc ? cfg_prescale  : m_psc;
      n_up   = acc ? cfg_upnotdown : m_up;
      n_prev = count_val;
      n_mask = m_cr;
      if (m_cr || (m_ud && m_mode == 0)) n_dir = m_up;
      if (m_mode == 0) begin
         n_ud = acc;
         if (start && !stop) begin
            n_mode = 1;
            n_cr   = 1'b1;
         end
      end else begin
         n_pd = wrap;
         if (stop) begin
            n_mode = 0;
            n_ud   = (m_mode == 2) || acc;
         end else if (m_mode == 2) begin
            if (wrap) begin
               n_mode = 1;
               n_ud   = 1'b1;
               n_dir  = m_up;
            end
         end else if (acc) begin
            if (cfg_immediate || m_per == 0) begin
               n_cr = 1'b1;
               n_ud = 1'b1;
            end else begin
               n_mode = 2;
            end
         end
      end
      if (!rst_n) begin
         n_mode = 0; n_per = '0; n_psc = '0; n_up = 1'b0; n_dir = 1'b0;
         n_prev = '0; n_mask = 1'b1; n_cr = 1'b0; n_ud = 1'b0; n_pd = 1'b0;
      end

      ne_cnt = e_cnt; ne_pre = e_pre; ne_per = e_per; ne_psc = e_psc; ne_up = e_up;
      if (count_reset || !en) begin
         ne_per = int'(period); ne_psc = int'(prescale); ne_up = upnotdown;
         if (count_reset) begin
            ne_cnt = 0;
            ne_pre = 0;
         end
      end else if (e_pre < e_psc) begin
         ne_pre = e_pre + 1;
      end else begin
         ne_pre = 0;
         if (e_up) begin
            if (e_cnt >= e_per) begin
               ne_cnt = 0;
               ne_per = int'(period); ne_psc = int'(prescale); ne_up = upnotdown;
            end else begin
               ne_cnt = e_cnt + 1;
            end
         end else if (e_cnt == 0) begin
            ne_per = int'(period); ne_psc = int'(prescale); ne_up = upnotdown;
            ne_cnt = int'(period);
         end else begin
            ne_cnt = e_cnt - 1;
         end
      end

      @(posedge clk);
      #1;
      m_mode = n_mode; m_per = n_per; m_psc = n_psc; m_up = n_up; m_dir = n_dir;
      m_prev = n_prev; m_mask = n_mask; m_cr = n_cr; m_ud = n_ud; m_pd = n_pd;
      e_cnt = ne_cnt; e_pre = ne_pre; e_per = ne_per; e_psc = ne_psc; e_up = ne_up;
      count_val = 16'(e_cnt);
   endtask

   task automatic send_cfg(input int per, input int psc, input logic up, input logic imm);
      cfg_period    = 16'(per);
      cfg_prescale  = 8'(psc);
      cfg_upnotdown = up;
      cfg_immediate = imm;
      cfg_valid     = 1'b1;
      cycle();
      cfg_valid     = 1'b0;
   endtask

   initial begin
      int   exp_seq [6];
      int   n_seen, t, t_first;
      logic seen;

      rst_n = 1'b0; start = 1'b0; stop = 1'b0; cfg_valid = 1'b0;
      cfg_period = '0; cfg_prescale = '0; cfg_upnotdown = 1'b0; cfg_immediate = 1'b0;
      count_val = '0;
      @(posedge clk);
      #1;
      cycle();
      cycle();
      rst_n = 1'b1;
      cycle();
      chk("reset_ready", 32'(cfg_ready), 1);
      chk("reset_en", 32'(en), 0);

      start = 1'b1;
      cycle();
      start = 1'b0;
      chk("start_reset", 32'(count_reset), 1);
      chk("start_en", 32'(en), 1);

      // deferred request while the active period is zero behaves as immediate
      send_cfg(5, 0, 1'b1, 1'b0);
      chk("promote_reset", 32'(count_reset), 1);
      chk("promote_done", 32'(upd_done), 1);
      chk("promote_ready", 32'(cfg_ready), 1);

      send_cfg(4, 0, 1'b1, 1'b1);
      repeat (3) cycle();
      send_cfg(4, 0, 1'b1, 1'b0);
      chk("defer_ready_low", 32'(cfg_ready), 0);
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         cycle();
         if (upd_done) begin
            seen = 1'b1;
            break;
         end
      end
      chk("defer_done_seen", 32'(seen), 1);
      chk("defer_period_done", 32'(period_done), 1);
      chk("defer_ready_back", 32'(cfg_ready), 1);
      chk("defer_wrap_to", 32'(cv_now), 0);
      chk("defer_wrap_from", 32'(cv_p1), 4);

      send_cfg(10, 0, 1'b1, 1'b1);
      repeat (15) cycle();
      send_cfg(3, 0, 1'b0, 1'b1);
      chk("imm_reset", 32'(count_reset), 1);
      chk("imm_done", 32'(upd_done), 1);
      exp_seq = '{0, 3, 2, 1, 0, 3};
      for (int i = 0; i < 6; i++) begin
         cycle();
         chk("imm_seq", 32'(count_val), 32'(exp_seq[i]));
         if (i == 1) chk("imm_no_spurious_pd", 32'(period_done), 0);
      end

      send_cfg(20, 0, 1'b0, 1'b0);
      chk("stop_pend_ready", 32'(cfg_ready), 0);
      stop = 1'b1;
      cycle();
      stop = 1'b0;
      chk("stop_pend_en", 32'(en), 0);
      chk("stop_pend_done", 32'(upd_done), 1);
      chk("stop_pend_ready", 32'(cfg_ready), 1);

      start = 1'b1;
      stop  = 1'b1;
      cycle();
      start = 1'b0;
      stop  = 1'b0;
      chk("startstop_en", 32'(en), 0);
      chk("startstop_reset", 32'(count_reset), 0);

      send_cfg(2, 1, 1'b0, 1'b0);
      chk("idle_upd_done", 32'(upd_done), 1);
      start = 1'b1;
      cycle();
      start = 1'b0;
      n_seen  = 0;
      t       = 0;
      t_first = 0;
      for (int i = 0; i < 40 && n_seen < 2; i++) begin
         cycle();
         t++;
         if (period_done) begin
            chk("down_wrap_to", 32'(cv_now), 2);
            chk("down_wrap_from", 32'(cv_p1), 0);
            if (n_seen == 0) t_first = t;
            else chk("down_pd_spacing", 32'(t - t_first), 6);
            n_seen++;
         end
      end
      chk("down_pd_pulses", 32'(n_seen), 2);

      for (int i = 0; i < 1500; i++) begin
         rst_n         = ($urandom_range(0, 299) != 0);
         start         = ($urandom_range(0, 11) == 0);
         stop          = ($urandom_range(0, 39) == 0);
         cfg_valid     = ($urandom_range(0, 3) == 0);
         cfg_period    = 16'($urandom_range(0, 6));
         cfg_prescale  = 8'($urandom_range(0, 2));
         cfg_upnotdown = 1'($urandom_range(0, 1));
         cfg_immediate = ($urandom_range(0, 2) == 0);
         cycle();
      end
      rst_n = 1'b1; start = 1'b0; stop = 1'b0; cfg_valid = 1'b0;
      repeat (3) cycle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/counter_ctrl.md
# counter_ctrl

Configuration and run-control sequencer for the PWM period counter. It accepts configuration updates over a valid/ready handshake, starts and stops the counter, and applies each update either immediately (by resetting the counter) or glitch-free at the next period boundary. It sits between the register interface and the counter, and owns every counter-facing control input.

## Interface
- No parameters. Widths are fixed: period 16 b, prescale 8 b.
- `clk` in 1: peripheral clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `start` in 1: one-cycle start request.
- `stop` in 1: one-cycle stop request.
- `cfg_valid` in 1: an update request is presented.
- `cfg_ready` out 1: the block can accept an update.
- `cfg_period` in 16: requested period.
- `cfg_prescale` in 8: requested prescale.
- `cfg_upnotdown` in 1: requested direction (1 = up).
- `cfg_immediate` in 1: 1 = apply now via counter reset; 0 = defer to the period boundary.
- `count_val` in 16: live counter value.
- `period` out 16: to the counter.
- `prescale` out 8: to the counter.
- `upnotdown` out 1: to the counter.
- `en` out 1: counter enable.
- `count_reset` out 1: one-cycle counter reset/load.
- `upd_done` out 1: one-cycle pulse when an accepted update is in effect in the counter.
- `period_done` out 1: one-cycle pulse per detected period wrap while running.

## Operation
- All outputs are registered. After reset: state IDLE, every output 0 except `cfg_ready`=1. `prev_cnt`=0, `act_dir`=0, and the wrap mask is set.
- States:
  - IDLE: `en`=0.
  - RUN: `en`=1, no update outstanding.
  - PEND: `en`=1, deferred update waiting for a wrap.
- `cfg_ready` = (state != PEND). An update is accepted when `cfg_valid` && `cfg_ready`, and on acceptance `period`/`prescale`/`upnotdown` load from the `cfg_*` inputs.
- Accept in IDLE: `upd_done` next cycle. The counter samples its ports continuously while disabled.
- Accept in RUN with `cfg_immediate`=1, or with active `period`==0: pulse `count_reset`, pulse `upd_done` in the same cycle, stay in RUN. A period of 0 produces no observable wrap, so such updates are promoted to immediate.
- Accept in RUN, otherwise: go to PEND. The counter picks up the new ports at its own boundary.
- Wrap detection:
  - `prev_cnt` registers `count_val` each cycle.
  - Up (`act_dir`=1): wrap = `count_val` < `prev_cnt`.
  - Down: wrap = `count_val` > `prev_cnt`.
  - Detection is masked for the one cycle after any `count_reset`.
- Wrap in RUN or PEND: pulse `period_done`.
- Wrap in PEND: also pulse `upd_done`, set `act_dir` = `upnotdown`, go to RUN.
- `start` in IDLE: pulse `count_reset` with `en`=1 in the same cycle, go to RUN. `start` in RUN or PEND is ignored.
- `stop` in RUN: `en`=0, go to IDLE.
- `stop` in PEND: `en`=0, pulse `upd_done` (the disabled counter samples its ports), go to IDLE.
- Simultaneous events:
  - `stop` and `start` together: `stop` wins.
  - `start` and an update accepted in IDLE: both take effect, so the counter resets with the new config, `upd_done` and `count_reset` pulse together, go to RUN.
  - `stop` and a wrap in PEND: a single `upd_done` pulse.
- `act_dir` also loads from `upnotdown` on every `count_reset` and on every update completed while in IDLE.
- Reset mid-operation returns to the reset values. Any pending update is dropped without `upd_done`.

## Timing
- Handshake at edge N: new ports visible at N+1.
  - Immediate: `count_reset` and `upd_done` high in cycle N+1.
  - IDLE: `upd_done` high in cycle N+1.
- Deferred: wrap visible on `count_val` in cycle W; `upd_done`/`period_done` high in cycle W+1; `cfg_ready` back to 1 in W+1.
- `start` sampled at edge N: `count_reset`=1 and `en`=1 in cycle N+1.
- `stop` sampled at edge N: `en`=0 in cycle N+1.
- Throughput: one update per cycle in IDLE and for immediate updates; one outstanding deferred update.

## Structure
- Shared `pwm_pkg` holds:
  - the state enum (IDLE, RUN, PEND);
  - width constants: `PERIOD_W`=16, `PRESCALE_W`=8.
- One sub-module: `wrap_detect`, containing `prev_cnt`, the direction-aware compare and the post-reset mask. Output: a 1-cycle `wrap` flag.

## Test plan
- Reset, then `start`, then update (period=4, prescale=0, up, deferred) → `count_reset`+`en` in the same cycle; `cfg_ready`=0 until the counter goes 4→0; `upd_done` and `period_done` one cycle after.
- Running (period=10, up), then immediate update (period=3, down) → `count_reset` and `upd_done` in the cycle after acceptance; `count_val` then runs 0,3,2,1,0,3 with no spurious `period_done` on the reset drop.
- Running with period=0, deferred update (period=5) → promoted to immediate: `count_reset` pulses and there is no PEND.
- Running, deferred update pending, then `stop` before the wrap → `en`=0 and `upd_done` in the same cycle; state IDLE.
- `start` and `stop` in the same cycle from IDLE → `en` stays 0, no `count_reset`.
- Down mode, period=2, prescale=1 → `period_done` every 6 cycles, one cycle after `count_val` 0→2.
